mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
- Parametrised successor to the co-processor's PC, instruction-address and SFR address-generation logic.
- A single FSM fetches instructions from a synchronous instruction RAM and decodes them.
- It streams strided activation/weight SRAM addresses into the PE array, aligns operand-valid and accumulator-clear to SRAM latency, and waits out the PE pipeline.
- It then writes the result to the output SRAM at an auto-incrementing address, and signals done or error.

Parameters:
- A_AW, 19, activation SRAM address width
- W_AW, 15, weight SRAM address width
- O_AW, 16, output SRAM address width
- INS_AW, 10, instruction RAM address width
- LEN_W, 12, MAC burst length field width
- PE_LAT, 3, PE array latency from operand-valid to result, in cycles (>=1)

Ports:
- clk  in  1  clock
- rstn  in  1  reset: asynchronous, active-low
- start  in  1  high pulse; begins execution at instruction 0 when idle
- hold  in  1  freezes FSM, counters and all outputs for the cycle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse on HALT or error
- err  out  1  sticky illegal-opcode flag; cleared by the next accepted start
- ins_rd  out  1  instruction read enable
- ins_addr  out  INS_AW  instruction address (pc)
- ins_data  in  32  instruction word, valid the cycle after ins_rd
- a_addr  out  A_AW  activation SRAM read address
- w_addr  out  W_AW  weight SRAM read address
- op_en  out  1  SRAM read enable for a_addr/w_addr
- pe_valid  out  1  operands valid at the PE; equals op_en delayed 1 cycle
- acc_clr  out  1  PE accumulator clear, coincident with pe_valid
- o_we  out  1  output SRAM write enable
- o_addr  out  O_AW  output SRAM write address

Behaviour:
- Reset: all outputs 0; pc, bases, strides (set to 1), o_addr and counters reset; FSM in IDLE.
- Opcodes in ins[31:28]:
  - 0 NOP.
  - 1 SETA: a_base = ins[A_AW-1:0].
  - 2 SETW: w_base = ins[W_AW-1:0].
  - 3 SETO: o_addr = ins[O_AW-1:0].
  - 4 SETS: a_stride = ins[7:0], w_stride = ins[15:8].
  - 5 MAC: len = ins[LEN_W-1:0], keep = ins[27], wb = ins[26].
  - 15 HALT.
  - Any other value is illegal.
- FSM states: IDLE, FETCH, DECODE, ISSUE, DRAIN, WB.
- IDLE: start=1 sets pc=0, clears err, sets busy=1 and goes to FETCH. start is ignored while busy.
- FETCH: ins_rd=1, ins_addr=pc; go to DECODE.
- DECODE: ins_data is consumed here.
  - SET*/NOP: update the register, pc+1, go to FETCH (2 cycles per instruction).
  - MAC with len=0: treated as NOP.
  - MAC with len>0: go to ISSUE.
  - HALT: done=1, busy=0, go to IDLE.
  - Illegal opcode: err=1, done=1, busy=0, go to IDLE.
- ISSUE: runs len cycles with op_en=1.
  - Beat i (0-based) drives a_addr = a_base + i*a_stride and w_addr = w_base + i*w_stride.
  - Addresses wrap modulo 2^A_AW and 2^W_AW.
  - acc_clr=1 on the pe_valid of beat 0 only, when keep=0; it is never asserted when keep=1.
  - After the last beat, a_base and w_base hold the next unissued address, so consecutive MACs stream.
  - Then go to DRAIN.
- DRAIN: exactly PE_LAT+1 cycles after the last op_en. Then go to WB if wb=1, else pc+1 and FETCH.
- WB: o_we=1 for one cycle at the current o_addr; o_addr+1 the following cycle (wraps); pc+1; go to FETCH.
- hold=1: state, counters and registered outputs are unchanged.
  - pe_valid and acc_clr deassert while hold=1; the held beat re-issues after hold drops.
  - Result: beats are never lost or duplicated.
- pc wraps from 2^INS_AW-1 to 0 silently.
- MAC latency: from DECODE to the o_we cycle is len + PE_LAT + 2 cycles.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; no o_we is issued.

Decomposition:
- Package mac_seq_pkg holds:
  - opcode localparams (OP_NOP..OP_HALT) and instruction field bit positions;
  - the state enum typedef.
- One sub-module, seq_addr_gen: base/stride accumulator with load, step and hold. Instantiated twice, for activations and weights.

Test Plan:
- Program SETA 0x100, SETW 0x20, MAC len=4 keep=0 wb=1, HALT -> a_addr 0x100..0x103, w_addr 0x20..0x23; acc_clr with first pe_valid only; o_we at o_addr 0 exactly 9 cycles after MAC DECODE; done pulses once.
- SETS a=2, w=3, then MAC len=3 twice, the second with keep=1 -> a_addr 0,2,4,6,8,10; w_addr 0,3,6,9,12,15; only one acc_clr; two o_we at o_addr 0 and 1.
- Assert hold for 2 cycles at beat 1 of MAC len=4 -> exactly 4 pe_valid pulses, no duplicate addresses, o_we delayed by 2 cycles.
- Opcode 0x7 at pc 2 -> err=1, done pulse, busy=0, no o_we. Next start clears err and restarts at pc 0.
- SETA 0x7FFFF then MAC len=2 -> a_addr 0x7FFFF then 0x00000. SETO 0xFFFF with two wb MACs -> o_addr 0xFFFF then 0x0000.
- Pulse start during ISSUE -> ignored. Drop rstn during DRAIN -> all outputs 0 in the same cycle and no o_we afterwards.

Source files
------------

// File: rtl/mac_sequencer_pkg.sv
// mac_seq_pkg: shared definitions for the MAC sequencer.
//   - opcode encodings carried in ins[31:28]
//   - instruction field bit positions
//   - FSM state enumeration
package mac_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_SETA = 4'h1;
  localparam logic [3:0] OP_SETW = 4'h2;
  localparam logic [3:0] OP_SETO = 4'h3;
  localparam logic [3:0] OP_SETS = 4'h4;
  localparam logic [3:0] OP_MAC  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB    = 31;
  localparam int OPC_LSB    = 28;
  localparam int KEEP_BIT   = 27;
  localparam int WB_BIT     = 26;
  localparam int SA_LSB     = 0;   // activation stride, 8 bits
  localparam int SW_LSB     = 8;   // weight stride, 8 bits

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_DRAIN,
    S_WB
  } state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// mac_seq_if: all non-clock signals of the MAC sequencer.
//   master : sequencer side (drives status, instruction fetch, SRAM/PE control)
//   slave  : environment side (drives start, hold, instruction word)
interface mac_seq_if #(
  parameter int A_AW   = 19,
  parameter int W_AW   = 15,
  parameter int O_AW   = 16,
  parameter int INS_AW = 10
);
  logic              start;
  logic              hold;
  logic              busy;
  logic              done;
  logic              err;
  logic              ins_rd;
  logic [INS_AW-1:0] ins_addr;
  logic [31:0]       ins_data;
  logic [A_AW-1:0]   a_addr;
  logic [W_AW-1:0]   w_addr;
  logic              op_en;
  logic              pe_valid;
  logic              acc_clr;
  logic              o_we;
  logic [O_AW-1:0]   o_addr;

  modport master (
    input  start, hold, ins_data,
    output busy, done, err, ins_rd, ins_addr, a_addr, w_addr,
           op_en, pe_valid, acc_clr, o_we, o_addr
  );

  modport slave (
    output start, hold, ins_data,
    input  busy, done, err, ins_rd, ins_addr, a_addr, w_addr,
           op_en, pe_valid, acc_clr, o_we, o_addr
  );
endinterface

// File: rtl/mac_sequencer_addr_gen.sv
// seq_addr_gen: strided address accumulator.
//   clk, rstn   : clock, async active-low reset
//   hold        : freezes base and stride
//   load/ld_val : load a new base address
//   stride_ld/stride_val : load a new 8-bit stride (resets to 1)
//   step        : advance base by stride (wraps modulo 2^AW)
//   addr        : current base, i.e. the next address to issue
module seq_addr_gen #(
  parameter int AW = 19
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          hold,
  input  logic          load,
  input  logic [AW-1:0] ld_val,
  input  logic          stride_ld,
  input  logic [7:0]    stride_val,
  input  logic          step,
  output logic [AW-1:0] addr
);
  logic [7:0] stride;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr   <= '0;
      stride <= 8'd1;
    end else if (!hold) begin
      if (stride_ld) stride <= stride_val;
      if (load)      addr   <= ld_val;
      else if (step) addr   <= addr + AW'(stride);
    end
  end
endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: instruction-driven MAC address sequencer.
//   clk, rstn : clock, async active-low reset
//   bus       : mac_seq_if.master -- start/hold control, busy/done/err status,
//               instruction fetch (ins_rd/ins_addr/ins_data), activation and
//               weight SRAM reads (a_addr/w_addr/op_en), PE control
//               (pe_valid/acc_clr), output SRAM write (o_we/o_addr).
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int A_AW   = 19,
  parameter int W_AW   = 15,
  parameter int O_AW   = 16,
  parameter int INS_AW = 10,
  parameter int LEN_W  = 12,
  parameter int PE_LAT = 3
) (
  input  logic      clk,
  input  logic      rstn,
  mac_seq_if.master bus
);
  localparam int DW = (PE_LAT + 1 > 1) ? $clog2(PE_LAT + 1) : 1;

  state_t            state, state_d;
  logic [INS_AW-1:0] pc;
  logic [LEN_W-1:0]  len_q, beat;
  logic [DW-1:0]     drain_cnt;
  logic              keep_q, wb_q;
  logic              busy_q, done_q, err_q;
  logic              vld_p1, acc_clr_p1;
  logic [O_AW-1:0]   o_addr_q;
  logic [A_AW-1:0]   a_acc;
  logic [W_AW-1:0]   w_acc;

  logic              accept, pc_adv, ld_a, ld_w, ld_s, ld_o, mac_go, halt, illegal;
  logic              last_beat, issuing;
  logic [3:0]        opcode;
  logic [LEN_W-1:0]  ins_len;
  logic              ins_unused;

  assign opcode     = bus.ins_data[OPC_MSB:OPC_LSB];
  assign ins_len    = bus.ins_data[LEN_W-1:0];
  assign ins_unused = ^bus.ins_data;
  assign last_beat  = (beat == len_q - 1'b1);
  assign issuing    = (state == S_ISSUE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    pc_adv  = 1'b0;
    ld_a    = 1'b0;
    ld_w    = 1'b0;
    ld_s    = 1'b0;
    ld_o    = 1'b0;
    mac_go  = 1'b0;
    halt    = 1'b0;
    illegal = 1'b0;
    if (!bus.hold) begin
      case (state)
        S_IDLE: if (bus.start) begin
          accept  = 1'b1;
          state_d = S_FETCH;
        end
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          state_d = S_FETCH;
          pc_adv  = 1'b1;
          case (opcode)
            OP_NOP:  ;
            OP_SETA: ld_a = 1'b1;
            OP_SETW: ld_w = 1'b1;
            OP_SETO: ld_o = 1'b1;
            OP_SETS: ld_s = 1'b1;
            // A zero-length MAC falls through as a NOP.
            OP_MAC: if (ins_len != '0) begin
              mac_go  = 1'b1;
              pc_adv  = 1'b0;
              state_d = S_ISSUE;
            end
            OP_HALT: begin
              halt    = 1'b1;
              pc_adv  = 1'b0;
              state_d = S_IDLE;
            end
            default: begin
              illegal = 1'b1;
              pc_adv  = 1'b0;
              state_d = S_IDLE;
            end
          endcase
        end
        S_ISSUE: if (last_beat) state_d = S_DRAIN;
        S_DRAIN: if (drain_cnt == DW'(PE_LAT)) begin
          if (wb_q) state_d = S_WB;
          else begin
            state_d = S_FETCH;
            pc_adv  = 1'b1;
          end
        end
        S_WB: begin
          state_d = S_FETCH;
          pc_adv  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc        <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      o_addr_q  <= '0;
      len_q     <= '0;
      beat      <= '0;
      keep_q    <= 1'b0;
      wb_q      <= 1'b0;
      drain_cnt <= '0;
    end else if (!bus.hold) begin
      done_q <= halt | illegal;
      if (accept) begin
        pc     <= '0;
        err_q  <= 1'b0;
        busy_q <= 1'b1;
      end else if (pc_adv) begin
        pc <= pc + 1'b1;
      end
      if (halt | illegal) busy_q <= 1'b0;
      if (illegal)        err_q  <= 1'b1;
      if (ld_o)                 o_addr_q <= bus.ins_data[O_AW-1:0];
      else if (state == S_WB)   o_addr_q <= o_addr_q + 1'b1;
      if (mac_go) begin
        len_q  <= ins_len;
        keep_q <= bus.ins_data[KEEP_BIT];
        wb_q   <= bus.ins_data[WB_BIT];
        beat   <= '0;
      end else if (issuing) begin
        beat <= beat + 1'b1;
      end
      if (issuing && last_beat)  drain_cnt <= '0;
      else if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Stage p0 -> p1: operands arrive from SRAM one cycle after op_en.
  // A held cycle issues no beat, so it produces no pe_valid; the frozen
  // beat is re-issued once hold drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1     <= 1'b0;
      acc_clr_p1 <= 1'b0;
    end else begin
      vld_p1     <= issuing && !bus.hold;
      acc_clr_p1 <= issuing && !bus.hold && (beat == '0) && !keep_q;
    end
  end

  seq_addr_gen #(.AW(A_AW)) u_a_gen (
    .clk        (clk),
    .rstn       (rstn),
    .hold       (bus.hold),
    .load       (ld_a),
    .ld_val     (bus.ins_data[A_AW-1:0]),
    .stride_ld  (ld_s),
    .stride_val (bus.ins_data[SA_LSB+7:SA_LSB]),
    .step       (issuing),
    .addr       (a_acc)
  );

  seq_addr_gen #(.AW(W_AW)) u_w_gen (
    .clk        (clk),
    .rstn       (rstn),
    .hold       (bus.hold),
    .load       (ld_w),
    .ld_val     (bus.ins_data[W_AW-1:0]),
    .stride_ld  (ld_s),
    .stride_val (bus.ins_data[SW_LSB+7:SW_LSB]),
    .step       (issuing),
    .addr       (w_acc)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.ins_rd   = (state == S_FETCH);
  assign bus.ins_addr = pc;
  assign bus.op_en    = issuing;
  assign bus.a_addr   = issuing ? a_acc : '0;
  assign bus.w_addr   = issuing ? w_acc : '0;
  assign bus.pe_valid = vld_p1;
  assign bus.acc_clr  = acc_clr_p1;
  assign bus.o_we     = (state == S_WB);
  assign bus.o_addr   = o_addr_q;
endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;
  localparam int A_AW = 19, W_AW = 15, O_AW = 16, INS_AW = 10, LEN_W = 12, PE_LAT = 3;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mac_seq_if #(.A_AW(A_AW), .W_AW(W_AW), .O_AW(O_AW), .INS_AW(INS_AW)) bus ();

  mac_sequencer #(
    .A_AW(A_AW), .W_AW(W_AW), .O_AW(O_AW), .INS_AW(INS_AW), .LEN_W(LEN_W), .PE_LAT(PE_LAT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Synchronous instruction RAM
  logic [31:0] mem [0:1023];
  always @(posedge clk) if (bus.ins_rd) bus.ins_data <= mem[bus.ins_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Event monitor
  logic [31:0] aq[$], wq[$], we_addr[$];
  int we_cyc[$];
  int pv_cnt, clr_cnt, clr_idx, clr_bad, done_cnt, first_op_cyc;
  always @(negedge clk) begin
    if (bus.op_en && !bus.hold) begin
      if (aq.size() == 0) first_op_cyc = cyc;
      aq.push_back(32'(bus.a_addr));
      wq.push_back(32'(bus.w_addr));
    end
    if (bus.acc_clr) begin
      clr_cnt++;
      clr_idx = pv_cnt;
      if (!bus.pe_valid) clr_bad++;
    end
    if (bus.pe_valid) pv_cnt++;
    if (bus.o_we) begin
      we_cyc.push_back(cyc);
      we_addr.push_back(32'(bus.o_addr));
    end
    if (bus.done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    aq.delete(); wq.delete(); we_addr.delete(); we_cyc.delete();
    pv_cnt = 0; clr_cnt = 0; clr_idx = -1; clr_bad = 0; done_cnt = 0; first_op_cyc = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    bit got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_op(input string tag, input int maxc);
    bit got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      if (bus.op_en) got = 1;
    end
    chk({tag, "_op_seen"}, 32'(got), 32'd1);
  endtask

  function automatic logic [31:0] i_seta(input logic [27:0] v); return {4'h1, v}; endfunction
  function automatic logic [31:0] i_setw(input logic [27:0] v); return {4'h2, v}; endfunction
  function automatic logic [31:0] i_seto(input logic [27:0] v); return {4'h3, v}; endfunction
  function automatic logic [31:0] i_sets(input logic [7:0] a, input logic [7:0] w);
    return {4'h4, 12'h0, w, a};
  endfunction
  function automatic logic [31:0] i_mac(input logic [11:0] len, input logic keep, input logic wb);
    return {4'h5, keep, wb, 14'h0, len};
  endfunction
  localparam logic [31:0] I_HALT = 32'hF000_0000;

  function automatic logic any_out();
    return |{bus.busy, bus.done, bus.err, bus.ins_rd, bus.ins_addr, bus.a_addr, bus.w_addr,
             bus.op_en, bus.pe_valid, bus.acc_clr, bus.o_we, bus.o_addr};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rstn = 1'b0; bus.start = 1'b0; bus.hold = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs_zero", 32'(any_out()), 32'd0);
    rstn = 1'b1;

    // Basic MAC with writeback; start pulsed during ISSUE is ignored
    mem[0] = i_seta(28'h100); mem[1] = i_setw(28'h20); mem[2] = i_mac(12'd4, 1'b0, 1'b1); mem[3] = I_HALT;
    clear_mon();
    pulse_start();
    chk("t1_busy_after_start", 32'(bus.busy), 32'd1);
    wait_op("t1", 50);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done("t1", 60);
    chk("t1_beats", aq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_a_addr%0d", i), aq[i], 32'h100 + i);
      chk($sformatf("t1_w_addr%0d", i), wq[i], 32'h20 + i);
    end
    chk("t1_pe_valid_cnt", pv_cnt, 32'd4);
    chk("t1_acc_clr_cnt", clr_cnt, 32'd1);
    chk("t1_acc_clr_first", clr_idx, 32'd0);
    chk("t1_acc_clr_with_valid", clr_bad, 32'd0);
    chk("t1_we_cnt", we_cyc.size(), 32'd1);
    chk("t1_we_latency", we_cyc[0] - first_op_cyc, 32'd8);
    chk("t1_we_addr", we_addr[0], 32'h0);
    chk("t1_done_once", done_cnt, 32'd1);
    chk("t1_busy_end", 32'(bus.busy), 32'd0);
    chk("t1_err_end", 32'(bus.err), 32'd0);

    // Strides, streaming bases, keep
    do_reset();
    mem[0] = i_sets(8'd2, 8'd3); mem[1] = i_mac(12'd3, 1'b0, 1'b1); mem[2] = i_mac(12'd3, 1'b1, 1'b1); mem[3] = I_HALT;
    clear_mon();
    pulse_start();
    wait_done("t2", 80);
    chk("t2_beats", aq.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_a_addr%0d", i), aq[i], 32'(2 * i));
      chk($sformatf("t2_w_addr%0d", i), wq[i], 32'(3 * i));
    end
    chk("t2_acc_clr_cnt", clr_cnt, 32'd1);
    chk("t2_pe_valid_cnt", pv_cnt, 32'd6);
    chk("t2_we_cnt", we_addr.size(), 32'd2);
    chk("t2_we_addr0", we_addr[0], 32'h0);
    chk("t2_we_addr1", we_addr[1], 32'h1);

    // Hold for two cycles at beat 1
    do_reset();
    mem[0] = i_mac(12'd4, 1'b0, 1'b1); mem[1] = I_HALT;
    clear_mon();
    pulse_start();
    wait_op("t3", 50);
    @(posedge clk); #1 bus.hold = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.hold = 1'b0;
    wait_done("t3", 60);
    chk("t3_pe_valid_cnt", pv_cnt, 32'd4);
    chk("t3_beats", aq.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_a_addr%0d", i), aq[i], 32'(i));
    chk("t3_we_latency", we_cyc[0] - first_op_cyc, 32'd10);

    // Illegal opcode at pc 2, then restart
    do_reset();
    mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'h7000_0000; mem[3] = i_mac(12'd1, 1'b0, 1'b1); mem[4] = I_HALT;
    clear_mon();
    pulse_start();
    wait_done("t4", 40);
    chk("t4_err", 32'(bus.err), 32'd1);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_done_once", done_cnt, 32'd1);
    chk("t4_no_we", we_cyc.size(), 32'd0);
    clear_mon();
    pulse_start();
    chk("t4_restart_err_clr", 32'(bus.err), 32'd0);
    chk("t4_restart_ins_rd", 32'(bus.ins_rd), 32'd1);
    chk("t4_restart_pc0", 32'(bus.ins_addr), 32'd0);
    wait_done("t4b", 40);
    chk("t4b_err", 32'(bus.err), 32'd1);

    // Address and o_addr wrap
    do_reset();
    mem[0] = i_seto(28'hFFFF); mem[1] = i_seta(28'h7FFFF); mem[2] = i_mac(12'd2, 1'b0, 1'b1);
    mem[3] = i_mac(12'd1, 1'b0, 1'b1); mem[4] = I_HALT;
    clear_mon();
    pulse_start();
    wait_done("t5", 80);
    chk("t5_a_addr0", aq[0], 32'h7FFFF);
    chk("t5_a_addr1", aq[1], 32'h00000);
    chk("t5_a_addr2", aq[2], 32'h00001);
    chk("t5_we_addr0", we_addr[0], 32'hFFFF);
    chk("t5_we_addr1", we_addr[1], 32'h0000);

    // Reset asserted during DRAIN
    do_reset();
    mem[0] = i_mac(12'd2, 1'b0, 1'b1); mem[1] = I_HALT;
    clear_mon();
    pulse_start();
    wait_op("t6", 50);
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_drain", 32'(bus.op_en), 32'd0);
    rstn = 1'b0;
    #1 chk("t6_outputs_zero", 32'(any_out()), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (15) @(negedge clk);
    chk("t6_no_we", we_cyc.size(), 32'd0);
    chk("t6_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
